// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the interval counter and its control initiator.
package counter_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  localparam logic [7:0] ST_RESET = 8'd0;
  localparam logic [7:0] ST_RUN   = 8'd1;
  localparam logic [7:0] ST_HALT  = 8'd2;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fsm_e;

  function automatic logic [7:0] st_enc(fsm_e s);
    unique case (s)
      S_RUN:   st_enc = ST_RUN;
      S_HALT:  st_enc = ST_HALT;
      default: st_enc = ST_RESET;
    endcase
  endfunction

endpackage

// File: rtl/counter_ctrl.sv
// Interval counter control: command FSM, target compare, done/irq.
// Build option COUNTER_CTRL_AUTO_RELOAD_EN: match restarts the run.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int BLANK_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_interval,
  input  logic [CNT_W-1:0] cmd_target,
  input  logic [CNT_W-1:0] counter_in,
  output logic [7:0]       state_out,
  output logic [CNT_W-1:0] interval_out,
  output logic             busy,
  output logic             done,
  output logic             irq,
  input  logic             irq_ack
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC + 1) : 1;

  fsm_e             fsm, nxt;
  op_e              op;
  logic [CNT_W-1:0] target_q;
  logic [BW-1:0]    blank_cnt;
  logic             match, hit;
  logic             load_iv, load_blank, clr_blank;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  logic             reload_q;
`endif

  assign op = (cmd_valid && cmd_ready) ? op_e'(cmd_op) : OP_NOP;

  assign match = (fsm == S_RUN) && (blank_cnt == '0) &&
                 (target_q != '0) && (counter_in >= target_q);

  // CLEAR beats a coincident match: no done, no irq
  assign hit = match && (op != OP_CLEAR);

  always_comb begin
    nxt        = fsm;
    load_iv    = 1'b0;
    load_blank = 1'b0;
    clr_blank  = 1'b0;
    unique case (fsm)
      S_IDLE: begin
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
        if (reload_q) begin
          if (op == OP_STOP) begin
            nxt = S_HALT;
          end else if (op == OP_CLEAR) begin
            nxt = S_IDLE;
          end else begin
            nxt        = S_RUN;
            load_blank = 1'b1;
          end
        end else
`endif
        if (op == OP_START) begin
          nxt        = S_RUN;
          load_iv    = 1'b1;
          load_blank = 1'b1;
        end
      end
      S_RUN: begin
        if (op == OP_CLEAR) begin
          nxt = S_IDLE;
        end else if (op == OP_STOP) begin
          nxt = S_HALT;
        end else if (match) begin
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
          nxt = S_IDLE;
`else
          nxt = S_HALT;
`endif
        end
      end
      S_HALT: begin
        if (op == OP_CLEAR) begin
          nxt = S_IDLE;
        end else if (op == OP_START) begin
          nxt       = S_RUN;
          clr_blank = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= S_IDLE;
      state_out    <= ST_RESET;
      interval_out <= '0;
      target_q     <= '0;
      blank_cnt    <= '0;
      done         <= 1'b0;
      irq          <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
      reload_q     <= 1'b0;
`endif
    end else begin
      fsm       <= nxt;
      state_out <= st_enc(nxt);
      busy      <= (nxt == S_RUN);
      cmd_ready <= 1'b1;
      done      <= hit;
      if (hit) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
      if (load_iv) begin
        interval_out <= cmd_interval;
        target_q     <= cmd_target;
      end
      if (load_blank) begin
        blank_cnt <= BW'(BLANK_CYC);
      end else if (clr_blank) begin
        blank_cnt <= '0;
      end else if (fsm == S_RUN && blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
      reload_q <= hit && (op != OP_STOP);
`endif
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed vector bench for counter_ctrl (default and auto-reload builds).
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_interval;
  logic [31:0] cmd_target;
  logic [31:0] counter_in;
  logic [7:0]  state_out;
  logic [31:0] interval_out;
  logic        busy;
  logic        done;
  logic        irq;
  logic        irq_ack;

  counter_ctrl #(.CNT_W(32), .BLANK_CYC(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_interval (cmd_interval),
    .cmd_target   (cmd_target),
    .counter_in   (counter_in),
    .state_out    (state_out),
    .interval_out (interval_out),
    .busy         (busy),
    .done         (done),
    .irq          (irq),
    .irq_ack      (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [31:0] iv;
    logic [31:0] tg;
    logic [31:0] cnt;
    logic        ack;
    logic [7:0]  st;
    logic [31:0] ivo;
    logic        bsy;
    logic        dn;
    logic        irq;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic add(logic v, logic [1:0] op, logic [31:0] iv,
                     logic [31:0] tg, logic [31:0] cnt, logic ack,
                     logic [7:0] st, logic [31:0] ivo, logic bsy,
                     logic dn, logic ir);
    vec_t r;
    r.v = v; r.op = op; r.iv = iv; r.tg = tg; r.cnt = cnt;
    r.ack = ack; r.st = st; r.ivo = ivo; r.bsy = bsy;
    r.dn = dn; r.irq = ir;
    vecs.push_back(r);
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [31:0] iv,
                       logic [31:0] tg, logic [31:0] cnt, logic ack);
    @(negedge clk);
    cmd_valid    = v;
    cmd_op       = op;
    cmd_interval = iv;
    cmd_target   = tg;
    counter_in   = cnt;
    irq_ack      = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_run;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_interval = '0; cmd_target = '0;
    counter_in = '0; irq_ack = 1'b0;
    #12;
    chk("rst st", 32'(state_out), 0);
    chk("rst ready", 32'(cmd_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst ivo", interval_out, 0);
    chk("rst done_irq", {30'd0, done, irq}, 0);
    @(negedge clk);
    rst = 1'b0;

`ifndef COUNTER_CTRL_AUTO_RELOAD_EN
    //  v op iv tg cnt ack | st ivo busy done irq
    add(0,0,0,0,0,0,         0,0,0,0,0);
    add(1,1,3,5,0,0,         1,3,1,0,0);
    add(0,0,0,0,5,0,         1,3,1,0,0);
    add(0,0,0,0,4,0,         1,3,1,0,0);
    add(0,0,0,0,5,0,         2,3,0,1,1);
    add(0,0,0,0,5,0,         2,3,0,0,1);
    add(0,0,0,0,5,1,         2,3,0,0,0);
    add(1,1,9,7,5,0,         1,3,1,0,0);
    add(0,0,0,0,6,0,         2,3,0,1,1);
    add(0,0,0,0,6,1,         2,3,0,0,0);
    add(1,1,0,0,0,0,         1,3,1,0,0);
    add(0,0,0,0,9,1,         2,3,0,1,1);
    add(0,0,0,0,9,1,         2,3,0,0,0);
    add(1,3,0,0,9,0,         0,3,0,0,0);
    add(1,2,0,0,9,0,         0,3,0,0,0);
    add(1,1,4,2,7,0,         1,4,1,0,0);
    add(0,0,0,0,7,0,         1,4,1,0,0);
    add(0,0,0,0,1,0,         1,4,1,0,0);
    add(0,0,0,0,2,0,         2,4,0,1,1);
    add(1,3,0,0,2,0,         0,4,0,0,1);
    add(1,1,8,0,0,0,         1,8,1,0,1);
    add(0,0,0,0,32'hFFFF_FFFF,0, 1,8,1,0,1);
    add(1,2,0,0,5,0,         2,8,0,0,1);
    add(1,1,0,0,5,0,         1,8,1,0,1);
    add(1,2,0,0,6,0,         2,8,0,0,1);
    add(1,3,0,0,6,1,         0,8,0,0,0);
    add(1,1,1,3,0,0,         1,1,1,0,0);
    add(0,0,0,0,3,0,         1,1,1,0,0);
    add(1,1,5,1,1,0,         1,1,1,0,0);
    add(1,3,0,0,3,0,         0,1,0,0,0);
    add(1,1,2,3,0,0,         1,2,1,0,0);
    add(0,0,0,0,0,0,         1,2,1,0,0);
    add(1,2,0,0,4,0,         2,2,0,1,1);
    add(0,0,0,0,4,0,         2,2,0,0,1);
`else
    add(1,1,3,4,0,0,         1,3,1,0,0);
    add(0,0,0,0,1,0,         1,3,1,0,0);
    add(0,0,0,0,3,0,         1,3,1,0,0);
    add(0,0,0,0,4,0,         0,3,0,1,1);
    add(0,0,0,0,0,0,         1,3,1,0,1);
    add(0,0,0,0,4,0,         1,3,1,0,1);
    add(0,0,0,0,4,0,         0,3,0,1,1);
    add(1,3,0,0,0,0,         0,3,0,0,1);
    add(0,0,0,0,0,0,         0,3,0,0,1);
    add(1,1,3,4,0,0,         1,3,1,0,1);
    add(0,0,0,0,0,0,         1,3,1,0,1);
    add(0,0,0,0,5,0,         0,3,0,1,1);
    add(1,2,0,0,0,0,         2,3,0,0,1);
    add(0,0,0,0,0,1,         2,3,0,0,0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].iv,
            vecs[i].tg, vecs[i].cnt, vecs[i].ack);
      chk($sformatf("r%0d st", i), 32'(state_out), 32'(vecs[i].st));
      chk($sformatf("r%0d ivo", i), interval_out, vecs[i].ivo);
      chk($sformatf("r%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("r%0d done", i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("r%0d irq", i), 32'(irq), 32'(vecs[i].irq));
      chk($sformatf("r%0d ready", i), 32'(cmd_ready), 1);
    end

    // Free-run: target 0 never halts over a long count
    drive(1, 2'd3, 0, 0, 0, 1);
    drive(1, 2'd1, 3, 0, 0, 0);
    bad_run = 0;
    for (int i = 0; i < 200; i++) begin
      drive(0, 2'd0, 0, 0, 32'(i * 7), 0);
      if (state_out !== ST_RUN || done !== 1'b0) bad_run++;
    end
    chk("freerun bad_cycles", 32'(bad_run), 0);
    drive(1, 2'd2, 0, 0, 1400, 0);
    chk("freerun stop st", 32'(state_out), 2);
    drive(1, 2'd1, 11, 22, 1400, 0);
    chk("freerun resume st", 32'(state_out), 1);
    chk("freerun resume ivo", interval_out, 3);

    // Async reset between edges, no clock edge in between
    drive(1, 2'd3, 0, 0, 0, 0);
    drive(1, 2'd1, 6, 0, 0, 0);
    chk("pre_rst st", 32'(state_out), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async st", 32'(state_out), 0);
    chk("async busy", 32'(busy), 0);
    chk("async ivo", interval_out, 0);
    chk("async ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
